apb_spi_ctrl: RTL and testbench
===============================

APB_SPI_CTRL -- requirements
Module: apb_spi_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, TX and RX FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk_i input 1 (clock, all logic on rising edge); rst_n_i input 1 (asynchronous reset, active low).
REQ-003 SHALL have these APB ports: psel_i in 1 select; penable_i in 1 access phase; pwrite_i in 1 write; paddr_bi in 4 byte address; pwdata_bi in 32 write data; prdata_bo out 32 read data; pready_o out 1 ready; pslverr_o out 1 error.
REQ-004 SHALL have these driver ports, for the downstream SPI master driver: drv_start_o out 1 start pulse; drv_data_bo out 8 byte to send; drv_busy_i in 1 driver busy; drv_data_bi in 8 byte received.
REQ-005 SHALL have irq_o out 1, level interrupt.

Function
REQ-006 SHALL hold pready_o=1 always (zero wait states); an access is the cycle with psel_i=penable_i=1.
REQ-007 SHALL decode the register map: 0x0 CTRL RW (bit0 EN, bit1 IRQ_EN); 0x4 STATUS; 0x8 TXDATA WO; 0xC RXDATA RO.
REQ-008 SHALL define STATUS bits: 0 TX_FULL, 1 TX_EMPTY, 2 RX_FULL, 3 RX_EMPTY, 4 BUSY (FSM not IDLE), 5 RX_OVF (sticky, write-1-to-clear); all other bits read 0.
REQ-009 SHALL push pwdata_bi[7:0] into the TX FIFO on a write to TXDATA when TX is not full.
REQ-010 SHALL pop the RX FIFO head onto prdata_bo[7:0] on a read of RXDATA when RX is not empty, with upper bits 0.
REQ-011 SHALL assert pslverr_o combinationally during an access, with no state change, for any of: write to TXDATA when TX_FULL; read of RXDATA when RX_EMPTY (prdata_bo=0); write to 0xC; read of 0x8; unmapped address.
REQ-012 SHALL drive prdata_bo=0 outside read accesses.
REQ-013 SHALL implement a sequencer FSM with states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-014 SHALL move IDLE->START when EN=1, TX is not empty and drv_busy_i=0; on this transition it SHALL pop the TX head into a register driving drv_data_bo.
REQ-015 SHALL assert drv_start_o only in START, for exactly one cycle, then move to WAIT_BUSY; drv_data_bo SHALL stay stable from START until the return to IDLE.
REQ-016 SHALL move WAIT_BUSY->WAIT_DONE on drv_busy_i=1.
REQ-017 SHALL, in WAIT_DONE on drv_busy_i=0, capture drv_data_bi into the RX FIFO and return to IDLE (2 cycles minimum between transfers).
REQ-018 SHALL, on capture with RX full and no same-cycle RXDATA pop, drop the byte and set RX_OVF; a same-cycle pop SHALL let the capture succeed.
REQ-019 SHALL evaluate TX full and RX empty on pre-edge counts: an APB push when TX is full is rejected even if the FSM pops the same cycle; an APB pop and an FSM push in the same cycle both take effect.
REQ-020 SHALL finish an in-flight transfer when EN is cleared, starting no new transfer.
REQ-021 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with counts 0..FIFO_DEPTH (width clog2(FIFO_DEPTH)+1).
REQ-022 SHALL register irq_o = IRQ_EN & (!RX_EMPTY | RX_OVF), updated one cycle after the cause changes.

Reset
REQ-023 SHALL, on rst_n_i=0 at any time including mid-transfer, immediately clear: FSM to IDLE, both FIFOs empty, CTRL=0, RX_OVF=0, drv_start_o=0, drv_data_bo=0, irq_o=0.
REQ-024 SHALL keep pslverr_o and prdata_bo combinational, so both read 0 during reset.
REQ-025 SHALL release reset with no transfer started until software sets EN.

Verification
REQ-026 Bench SHALL cover: write TXDATA 0xA5, CTRL=0x1, driver model loops MOSI to MISO -> one drv_start_o pulse with drv_data_bo=0xA5; RXDATA reads 0xA5; STATUS then reads TX_EMPTY=1, RX_EMPTY=1.
REQ-027 Bench SHALL cover: EN=0, five TXDATA writes with depth 4 -> first four OKAY, fifth pslverr_o=1; STATUS TX_FULL=1.
REQ-028 Bench SHALL cover: five transfers without RXDATA reads -> RX_FULL=1, RX_OVF=1, first four bytes retained in order; writing STATUS 0x20 clears RX_OVF.
REQ-029 Bench SHALL cover: read RXDATA when empty -> pslverr_o=1, prdata_bo=0; write to 0x4 bit0 with no overflow set -> no effect.
REQ-030 Bench SHALL cover: CTRL=0x3 and one transfer -> irq_o rises 1 cycle after capture and falls 1 cycle after the RXDATA pop.
REQ-031 Bench SHALL cover: rst_n_i pulsed low during WAIT_DONE -> all outputs 0 and STATUS=0x0A after release.

Source files
------------

// File: rtl/apb_spi_ctrl.sv
// apb_spi_ctrl: APB-programmable byte sequencer for a downstream SPI master driver.
// Software queues bytes in a TX FIFO; the sequencer hands each one to the driver,
// waits for the driver's busy handshake and stores the received byte in an RX FIFO.
//
// Ports:
//   clk_i, rst_n_i       clock (rising edge), asynchronous active-low reset
//   psel_i .. pslverr_o  APB slave, zero wait states, 4-bit byte address
//   drv_start_o          one-cycle start pulse to the SPI driver
//   drv_data_bo          byte to send, stable for the whole transfer
//   drv_busy_i           driver busy
//   drv_data_bi          byte received by the driver, valid when busy falls
//   irq_o                level interrupt: RX data available or RX overflow
module apb_spi_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [3:0]  paddr_bi,
    input  logic [31:0] pwdata_bi,
    output logic [31:0] prdata_bo,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic        drv_start_o,
    output logic [7:0]  drv_data_bo,
    input  logic        drv_busy_i,
    input  logic [7:0]  drv_data_bi,
    output logic        irq_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_TXDATA = 4'h8;
    localparam logic [3:0] ADDR_RXDATA = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_en;
    logic             r_irq_en;
    logic             r_rx_ovf;
    logic             r_irq;
    logic             r_drv_start;
    logic [7:0]       r_drv_data;

    logic [7:0]       r_tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_tx_wr_ptr;
    logic [PTR_W-1:0] r_tx_rd_ptr;
    logic [CNT_W-1:0] r_tx_cnt;

    logic [7:0]       r_rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rx_wr_ptr;
    logic [PTR_W-1:0] r_rx_rd_ptr;
    logic [CNT_W-1:0] r_rx_cnt;

    logic        w_access;
    logic        w_wr;
    logic        w_rd;
    logic        w_sel_ctrl;
    logic        w_sel_status;
    logic        w_sel_tx;
    logic        w_sel_rx;
    logic        w_mapped;
    logic        w_err;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic        w_busy;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic        w_capture;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic        w_ctrl_wr;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    // APB decode
    assign w_access     = psel_i & penable_i;
    assign w_wr         = w_access & pwrite_i;
    assign w_rd         = w_access & ~pwrite_i;
    assign w_sel_ctrl   = (paddr_bi == ADDR_CTRL);
    assign w_sel_status = (paddr_bi == ADDR_STATUS);
    assign w_sel_tx     = (paddr_bi == ADDR_TXDATA);
    assign w_sel_rx     = (paddr_bi == ADDR_RXDATA);
    assign w_mapped     = w_sel_ctrl | w_sel_status | w_sel_tx | w_sel_rx;

    // FIFO flags always come from pre-edge counts
    assign w_tx_full  = (r_tx_cnt == DEPTH_CNT);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == DEPTH_CNT);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_busy     = (r_state != ST_IDLE);

    // Error: illegal direction, unmapped address, or FIFO cannot accept/supply
    assign w_err = w_access & (~w_mapped
                             | (w_wr & w_sel_tx & w_tx_full)
                             | (w_rd & w_sel_rx & w_rx_empty)
                             | (w_wr & w_sel_rx)
                             | (w_rd & w_sel_tx));

    assign w_tx_push = w_wr & w_sel_tx & ~w_tx_full;
    assign w_rx_pop  = w_rd & w_sel_rx & ~w_rx_empty;
    assign w_ctrl_wr = w_wr & w_sel_ctrl;
    assign w_ovf_clr = w_wr & w_sel_status & pwdata_bi[5];

    // A same-cycle RXDATA pop frees a slot for the capture
    assign w_rx_push = w_capture & (~w_rx_full | w_rx_pop);
    assign w_ovf_set = w_capture & w_rx_full & ~w_rx_pop;

    assign w_status = {26'd0, r_rx_ovf, w_busy, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

    // Read mux; zero outside successful read accesses
    always_comb begin
        w_rdata = 32'd0;
        if (w_rd && !w_err) begin
            case (paddr_bi)
                ADDR_CTRL:   w_rdata = {30'd0, r_irq_en, r_en};
                ADDR_STATUS: w_rdata = w_status;
                ADDR_RXDATA: w_rdata = {24'd0, r_rx_mem[r_rx_rd_ptr]};
                default:     w_rdata = 32'd0;
            endcase
        end
    end

    assign prdata_bo = w_rdata;
    assign pslverr_o = w_err;
    assign pready_o  = 1'b1;

    // Sequencer next-state
    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_en && !w_tx_empty && !drv_busy_i) begin
                    w_state_nxt = ST_START;
                    w_tx_pop    = 1'b1;
                end
            end
            ST_START: begin
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (drv_busy_i) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!drv_busy_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and driver outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_drv_start <= 1'b0;
            r_drv_data  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drv_start <= (w_state_nxt == ST_START);
            if (w_tx_pop) begin
                r_drv_data <= r_tx_mem[r_tx_rd_ptr];
            end
        end
    end

    // Control, overflow flag and interrupt
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_rx_ovf <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_en     <= pwdata_bi[0];
                r_irq_en <= pwdata_bi[1];
            end
            // A new overflow wins over a same-cycle clear
            if (w_ovf_set) begin
                r_rx_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_rx_ovf <= 1'b0;
            end
            r_irq <= r_irq_en & (~w_rx_empty | r_rx_ovf);
        end
    end

    // TX FIFO pointers and count
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_cnt    <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + PTR_W'(1);
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + PTR_W'(1);
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // RX FIFO pointers and count
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_cnt    <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + PTR_W'(1);
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + PTR_W'(1);
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk_i) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= pwdata_bi[7:0];
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= drv_data_bi;
        end
    end

    assign drv_start_o = r_drv_start;
    assign drv_data_bo = r_drv_data;
    assign irq_o       = r_irq;

    // Upper write-data bits have no register behind them
    assign w_unused = ^pwdata_bi[31:8];

endmodule

// File: tb/tb_apb_spi_ctrl.sv
// Testbench for apb_spi_ctrl: APB stimulus pushes expected responses into
// scoreboard queues; monitors pop and compare on each APB access and each
// driver start pulse. A behavioural SPI driver model loops sent bytes back.
module tb_apb_spi_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [3:0]  paddr = 4'h0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        drv_start;
    logic [7:0]  drv_data_bo;
    logic        drv_busy = 1'b0;
    logic [7:0]  drv_rdata = 8'd0;
    logic        irq;

    apb_spi_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .psel_i      (psel),
        .penable_i   (penable),
        .pwrite_i    (pwrite),
        .paddr_bi    (paddr),
        .pwdata_bi   (pwdata),
        .prdata_bo   (prdata),
        .pready_o    (pready),
        .pslverr_o   (pslverr),
        .drv_start_o (drv_start),
        .drv_data_bo (drv_data_bo),
        .drv_busy_i  (drv_busy),
        .drv_data_bi (drv_rdata),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } apb_exp_t;

    apb_exp_t   apb_q[$];
    string      apb_name_q[$];
    logic [7:0] drv_q[$];

    int checks      = 0;
    int failures    = 0;
    int xfer_done   = 0;
    int start_count = 0;
    int busy_len    = 3;
    int rst_count   = 0;
    logic prev_start = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, act, exp);
        end
    endtask

    // One APB transfer; expectation queued when the access phase begins
    task automatic apb(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input string name);
        apb_exp_t e;
        @(posedge clk); #1;
        psel = 1'b1; pwrite = wr; paddr = addr; pwdata = wdata; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        apb_q.push_back(e);
        apb_name_q.push_back(name);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (xfer_done < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (xfer_done < target) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=%0d exp=%0d", name, xfer_done, target);
        end
    endtask

    // APB monitor
    always @(negedge clk) begin
        apb_exp_t e;
        string    n;
        if (rst_n && psel && penable) begin
            if (apb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL apb_unexpected_access got=addr 0x%h exp=none", paddr);
            end else begin
                e = apb_q.pop_front();
                n = apb_name_q.pop_front();
                chk({n, "_rdata"}, prdata, e.rdata);
                chk({n, "_slverr"}, 32'(pslverr), 32'(e.err));
                chk({n, "_pready"}, 32'(pready), 32'd1);
            end
        end
    end

    // Driver start monitor
    always @(negedge clk) begin
        logic [7:0] d;
        if (prev_start) begin
            chk("drv_start_width", 32'(drv_start), 32'd0);
        end
        if (rst_n && drv_start) begin
            start_count++;
            if (drv_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL drv_unexpected_start got=0x%02h exp=none", drv_data_bo);
            end else begin
                d = drv_q.pop_front();
                chk("drv_start_data", 32'(drv_data_bo), 32'(d));
            end
        end
        prev_start = rst_n & drv_start;
    end

    // SPI driver model: busy for busy_len cycles, returns the sent byte
    initial begin
        logic [7:0] b;
        int         rc;
        forever begin
            @(posedge clk); #1;
            if (rst_n && drv_start) begin
                b  = drv_data_bo;
                rc = rst_count;
                repeat (2) @(posedge clk);
                #1 drv_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1;
                if (rc == rst_count) begin
                    chk("drv_data_stable", 32'(drv_data_bo), 32'(b));
                end
                drv_rdata = b;
                drv_busy  = 1'b0;
                xfer_done++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_drv_start", 32'(drv_start), 32'd0);
        chk("rst_drv_data", 32'(drv_data_bo), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_slverr", 32'(pslverr), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        chk("post_rst_no_start", 32'(start_count), 32'd0);
        apb(1'b0, 4'h4, 0, 32'h0A, 1'b0, "rst_status");
        apb(1'b0, 4'h0, 0, 32'h00, 1'b0, "rst_ctrl");

        // Single loopback transfer
        base = xfer_done;
        drv_q.push_back(8'hA5);
        apb(1'b1, 4'h8, 32'hA5, 0, 1'b0, "t1_wr_tx");
        apb(1'b1, 4'h0, 32'h1, 0, 1'b0, "t1_wr_ctrl");
        wait_done(base + 1, "t1");
        repeat (2) @(posedge clk);
        chk("t1_start_count", 32'(start_count), 32'd1);
        apb(1'b0, 4'hC, 0, 32'hA5, 1'b0, "t1_rd_rx");
        apb(1'b0, 4'h4, 0, 32'h0A, 1'b0, "t1_status");

        // TX overfill with EN=0
        apb(1'b1, 4'h0, 32'h0, 0, 1'b0, "t2_wr_ctrl");
        apb(1'b1, 4'h8, 32'h11, 0, 1'b0, "t2_tx0");
        apb(1'b1, 4'h8, 32'h22, 0, 1'b0, "t2_tx1");
        apb(1'b1, 4'h8, 32'h33, 0, 1'b0, "t2_tx2");
        apb(1'b1, 4'h8, 32'h44, 0, 1'b0, "t2_tx3");
        apb(1'b1, 4'h8, 32'h99, 0, 1'b1, "t2_tx4_full");
        apb(1'b0, 4'h4, 0, 32'h09, 1'b0, "t2_status");

        // Five transfers, no reads: RX overflow
        base = xfer_done;
        drv_q.push_back(8'h11);
        drv_q.push_back(8'h22);
        drv_q.push_back(8'h33);
        drv_q.push_back(8'h44);
        drv_q.push_back(8'h55);
        apb(1'b1, 4'h0, 32'h1, 0, 1'b0, "t3_wr_ctrl");
        wait_done(base + 1, "t3_first");
        apb(1'b1, 4'h8, 32'h55, 0, 1'b0, "t3_tx5");
        wait_done(base + 5, "t3_all");
        repeat (2) @(posedge clk);
        #1 chk("t3_irq_disabled", 32'(irq), 32'd0);
        apb(1'b0, 4'h4, 0, 32'h26, 1'b0, "t3_status_ovf");
        apb(1'b1, 4'h4, 32'h20, 0, 1'b0, "t3_clr_ovf");
        apb(1'b0, 4'h4, 0, 32'h06, 1'b0, "t3_status_clr");
        apb(1'b0, 4'hC, 0, 32'h11, 1'b0, "t3_rx0");
        apb(1'b0, 4'hC, 0, 32'h22, 1'b0, "t3_rx1");
        apb(1'b0, 4'hC, 0, 32'h33, 1'b0, "t3_rx2");
        apb(1'b0, 4'hC, 0, 32'h44, 1'b0, "t3_rx3");
        apb(1'b0, 4'h4, 0, 32'h0A, 1'b0, "t3_status_end");

        // Error responses and harmless STATUS write
        apb(1'b0, 4'hC, 0, 32'h0, 1'b1, "t4_rx_empty");
        apb(1'b1, 4'h4, 32'h1, 0, 1'b0, "t4_wr_status");
        apb(1'b0, 4'h4, 0, 32'h0A, 1'b0, "t4_status");
        apb(1'b1, 4'hC, 32'h12, 0, 1'b1, "t4_wr_rxdata");
        apb(1'b0, 4'h8, 0, 32'h0, 1'b1, "t4_rd_txdata");
        apb(1'b0, 4'h2, 0, 32'h0, 1'b1, "t4_rd_unmapped");
        apb(1'b1, 4'hF, 32'h1, 0, 1'b1, "t4_wr_unmapped");
        apb(1'b0, 4'h0, 0, 32'h1, 1'b0, "t4_rd_ctrl");

        // Interrupt timing
        base = xfer_done;
        apb(1'b1, 4'h0, 32'h3, 0, 1'b0, "t5_wr_ctrl");
        drv_q.push_back(8'h5A);
        apb(1'b1, 4'h8, 32'h5A, 0, 1'b0, "t5_wr_tx");
        wait_done(base + 1, "t5");
        chk("t5_irq_before_capture", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t5_irq_capture_cycle", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t5_irq_rise", 32'(irq), 32'd1);
        apb(1'b0, 4'hC, 0, 32'h5A, 1'b0, "t5_rd_rx");
        @(negedge clk);
        chk("t5_irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        chk("t5_irq_fall", 32'(irq), 32'd0);

        // Reset during WAIT_DONE
        base = xfer_done;
        drv_q.push_back(8'h66);
        apb(1'b1, 4'h8, 32'h66, 0, 1'b0, "t6_wr_tx0");
        wait_done(base + 1, "t6_first");
        repeat (3) @(negedge clk);
        chk("t6_irq_pre", 32'(irq), 32'd1);
        busy_len = 20;
        drv_q.push_back(8'h77);
        apb(1'b1, 4'h8, 32'h77, 0, 1'b0, "t6_wr_tx1");
        n = 0;
        while (!drv_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_busy_seen", 32'(drv_busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_drv_data_pre", 32'(drv_data_bo), 32'h77);
        rst_count++;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_drv_start", 32'(drv_start), 32'd0);
        chk("t6_rst_drv_data", 32'(drv_data_bo), 32'd0);
        chk("t6_rst_irq", 32'(irq), 32'd0);
        chk("t6_rst_prdata", prdata, 32'd0);
        chk("t6_rst_slverr", 32'(pslverr), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        apb(1'b0, 4'h4, 0, 32'h0A, 1'b0, "t6_status");
        apb(1'b0, 4'h0, 0, 32'h0, 1'b0, "t6_ctrl");
        busy_len = 3;
        repeat (40) @(posedge clk);
        #1;
        chk("t6_irq_after", 32'(irq), 32'd0);
        chk("total_starts", 32'(start_count), 32'd9);
        chk("drv_q_empty", 32'(drv_q.size()), 32'd0);
        chk("apb_q_empty", 32'(apb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
